cyclic_lamp_ctrl: RTL
=====================

# cyclic_lamp_ctrl

Parametrised two-approach cyclic lamp sequencer, the successor to the single-lamp RGY cycler. It drives two conflicting lamp heads (approach A, approach B) through green, yellow and all-red clearance phases with configurable dwell times. It adds a pedestrian request/walk handshake, a maintenance flash mode and a global enable. It sits between the board timing tick and the lamp driver outputs.

## Interface
- CNT_W, 8: dwell counter width.
- GREEN_CYC, 20: green dwell, cycles.
- YELLOW_CYC, 4: yellow dwell, cycles.
- RED_CLR_CYC, 2: all-red clearance dwell, cycles.
- MIN_GREEN, 8: minimum green before a pedestrian request may truncate it.
- WALK_CYC, 10: walk phase dwell, cycles.
- FLASH_HALF, 5: flash half-period, cycles.
- Legality: all durations ≥1 and < 2^CNT_W; MIN_GREEN ≤ GREEN_CYC.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  1 = advance; 0 = freeze state, counter and outputs.
- flash_req  in  1  level; 1 = maintenance flash.
- ped_req  in  1  pedestrian request, pulse or level.
- light_a  out  [0:2]  approach A lamps, bit0=R, bit1=G, bit2=Y.
- light_b  out  [0:2]  approach B lamps, same encoding.
- walk  out  1  pedestrian walk lamp.
- ped_ack  out  1  one-cycle pulse on entry to WALK.
- phase  out  3  current state code, for debug.

## Operation
- States: A_GREEN, A_YELLOW, CLR_1, B_GREEN, B_YELLOW, CLR_2, WALK, FLASH.
- Normal cycle: A_GREEN → A_YELLOW → CLR_1 → B_GREEN → B_YELLOW → CLR_2 → A_GREEN.
- Lamps per state:
  - Green on the active approach (010), red (100) on the other.
  - Yellow (001) on the active approach, red on the other.
  - CLR and WALK: both heads 100.
  - FLASH: both heads alternate 001 and 000.
- Dwell: an up-counter clears on state entry. The state exits when the counter equals its duration−1 and en=1.
- Pedestrian: ped_req sets the ped_pend register; holding the request at level has the same effect as a single pulse.
  - During a green with ped_pend=1, the green exits as soon as the counter is ≥ MIN_GREEN−1.
  - At the end of CLR_1 or CLR_2 with ped_pend=1, the next state is WALK instead of green.
  - On WALK entry, ped_ack pulses for one cycle and ped_pend clears.
  - ped_req during WALK is ignored.
  - WALK exits to the green that would otherwise have followed.
- Flash: flash_req=1 forces FLASH on the next edge from any state and clears ped_pend.
  - The flash counter starts at entry with the lamps on (001).
  - When flash_req falls, the block goes to CLR_2 with the counter cleared, then A_GREEN.
- en=0: freezes the counter and state, including the flash blink. ped_req is still latched.
- Priority on the same edge: reset > flash_req > en gating > dwell expiry > ped truncation.

## Timing
- All outputs are registered and update on the same edge as the state change; no combinational input-to-output paths.
- Reset values: state CLR_2, counter 0, ped_pend 0, light_a=light_b=100, walk 0, ped_ack 0, phase = CLR_2 code.
- After rst_n rises, light_a goes 010 after RED_CLR_CYC cycles.
- Default period with no requests: 2×(20+4+2) = 52 cycles.
- ped_req registered at edge n is visible to truncation logic at edge n+1.
- rst_n assertion mid-phase, including WALK and FLASH, returns everything to reset values immediately.

## Configuration
- Macro: CYCLIC_LAMP_PED_EN.
- Defined: pedestrian logic present as described.
- Undefined: ped_pend logic removed, WALK unreachable, walk and ped_ack tied 0, ped_req ignored. The rest of the cycle is unchanged.

## Structure
- Package cyclic_lamp_pkg holds:
  - the state enum and phase codes;
  - lamp encoding constants LAMP_RED=100, LAMP_GRN=010, LAMP_YEL=001, LAMP_OFF=000.
- Sub-module cyclic_lamp_timer: CNT_W up-counter with clear, enable and compare-to-duration, giving a done output. The FSM and lamp decode stay in the top level.

## Test plan
- Reset release, en=1, no requests: light_a shows 100 ×2, 010 ×20, 001 ×4, then 100 ×28; light_b is mirrored with a 26-cycle offset; the 52-cycle period repeats.
- One-cycle ped_req at A_GREEN cycle 3: A_GREEN lasts 8 cycles, then A_YELLOW 4, CLR_1 2, WALK 10 with walk=1 and ped_ack=1 on the first WALK cycle only, then B_GREEN 20.
- flash_req raised at B_GREEN cycle 6: both heads go 001 ×5, 000 ×5, repeating. After flash_req falls: both 100 ×2, then light_a=010.
- en=0 for 7 cycles during A_YELLOW: yellow lasts 11 cycles total and other outputs are unchanged.
- rst_n pulsed low mid-WALK: same cycle, walk=0 and both heads 100; a later CLR_2 exit goes to A_GREEN, not WALK.
- CYCLIC_LAMP_PED_EN undefined, ped_req pulsed every 10 cycles: the sequence is identical to the first scenario, with walk=0 and ped_ack=0 throughout.

Source files
------------

// File: rtl/cyclic_lamp_pkg.sv
// cyclic_lamp_pkg: state codes and lamp encodings shared by cyclic_lamp_ctrl
package cyclic_lamp_pkg;
  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    CLR_1    = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    CLR_2    = 3'd5,
    WALK     = 3'd6,
    FLASH    = 3'd7
  } state_t;
  localparam logic [0:2] LAMP_RED = 3'b100;
  localparam logic [0:2] LAMP_GRN = 3'b010;
  localparam logic [0:2] LAMP_YEL = 3'b001;
  localparam logic [0:2] LAMP_OFF = 3'b000;
endpackage

// File: rtl/cyclic_lamp_ctrl_if.sv
// cyclic_lamp_ctrl_if: control inputs and lamp outputs of cyclic_lamp_ctrl
interface cyclic_lamp_ctrl_if;
  logic       en;
  logic       flash_req;
  logic       ped_req;
  logic [0:2] light_a;
  logic [0:2] light_b;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;
  modport master (output en, flash_req, ped_req,
                  input  light_a, light_b, walk, ped_ack, phase);
  modport slave  (input  en, flash_req, ped_req,
                  output light_a, light_b, walk, ped_ack, phase);
endinterface

// File: rtl/cyclic_lamp_timer.sv
// cyclic_lamp_timer: dwell up-counter with clear/enable and terminal-count compare
module cyclic_lamp_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_last,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_done
);
  logic [CNT_W-1:0] r_cnt;
  // clear wins over counting; en=0 holds the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + CNT_W'(1);
  end
  assign o_cnt  = r_cnt;
  assign o_done = r_cnt == i_last;
endmodule

// File: rtl/cyclic_lamp_ctrl.sv
// cyclic_lamp_ctrl: two-approach lamp sequencer; pedestrian logic built when CYCLIC_LAMP_PED_EN is defined
module cyclic_lamp_ctrl #(
  parameter int CNT_W       = 8,
  parameter int GREEN_CYC   = 20,
  parameter int YELLOW_CYC  = 4,
  parameter int RED_CLR_CYC = 2,
  parameter int MIN_GREEN   = 8,
  parameter int WALK_CYC    = 10,
  parameter int FLASH_HALF  = 5
) (
  input logic               clk,
  input logic               rst_n,
  cyclic_lamp_ctrl_if.slave bus
);
  import cyclic_lamp_pkg::*;
  localparam logic [CNT_W-1:0] L_GRN = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] L_YEL = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] L_CLR = CNT_W'(RED_CLR_CYC - 1);
  localparam logic [CNT_W-1:0] L_WLK = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] L_FLS = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] L_MIN = CNT_W'(MIN_GREEN - 1);
  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] w_last, w_cnt;
  logic             w_done, w_clr, w_trunc, w_blink, w_pend, w_walk_b;
  logic             r_flash_on, w_flash_on_nxt;
  logic [0:2]       r_light_a, r_light_b, w_lamp_a, w_lamp_b;
  logic             w_walk_entry;
  cyclic_lamp_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_en   (bus.en),
    .i_last (w_last),
    .o_cnt  (w_cnt),
    .o_done (w_done)
  );
  // terminal count for the dwell of the current state
  always_comb begin
    w_last = (r_state == A_GREEN  || r_state == B_GREEN ) ? L_GRN :
             (r_state == A_YELLOW || r_state == B_YELLOW) ? L_YEL :
             (r_state == WALK)                            ? L_WLK :
             (r_state == FLASH)                           ? L_FLS : L_CLR;
  end
  assign w_trunc      = w_pend && (w_cnt >= L_MIN);
  assign w_blink      = (r_state == FLASH) && bus.flash_req && bus.en && w_done;
  assign w_clr        = (w_nxt != r_state) || w_blink;
  assign w_walk_entry = (w_nxt == WALK) && (r_state != WALK);
  // next state: flash overrides everything, en=0 freezes, then dwell expiry / ped truncation
  always_comb begin
    w_nxt = r_state;
    if (bus.flash_req) w_nxt = FLASH;
    else if (bus.en) begin
      case (r_state)
        A_GREEN:  if (w_done || w_trunc) w_nxt = A_YELLOW;
        A_YELLOW: if (w_done) w_nxt = CLR_1;
        CLR_1:    if (w_done) w_nxt = w_pend ? WALK : B_GREEN;
        B_GREEN:  if (w_done || w_trunc) w_nxt = B_YELLOW;
        B_YELLOW: if (w_done) w_nxt = CLR_2;
        CLR_2:    if (w_done) w_nxt = w_pend ? WALK : A_GREEN;
        WALK:     if (w_done) w_nxt = w_walk_b ? B_GREEN : A_GREEN;
        default:  w_nxt = CLR_2;
      endcase
    end
  end
  // lamps for the state being entered, so the registered outputs move with the state
  always_comb begin
    w_flash_on_nxt = (r_state != FLASH) ? 1'b1 : w_blink ? ~r_flash_on : r_flash_on;
    w_lamp_a = LAMP_RED;
    w_lamp_b = LAMP_RED;
    case (w_nxt)
      A_GREEN:  w_lamp_a = LAMP_GRN;
      A_YELLOW: w_lamp_a = LAMP_YEL;
      B_GREEN:  w_lamp_b = LAMP_GRN;
      B_YELLOW: w_lamp_b = LAMP_YEL;
      FLASH: begin
        w_lamp_a = w_flash_on_nxt ? LAMP_YEL : LAMP_OFF;
        w_lamp_b = w_flash_on_nxt ? LAMP_YEL : LAMP_OFF;
      end
      default: ;
    endcase
  end
  // state and registered lamp outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CLR_2;
      r_flash_on <= 1'b0;
      r_light_a  <= LAMP_RED;
      r_light_b  <= LAMP_RED;
    end else begin
      r_state    <= w_nxt;
      r_flash_on <= w_flash_on_nxt;
      r_light_a  <= w_lamp_a;
      r_light_b  <= w_lamp_b;
    end
  end
  assign bus.light_a = r_light_a;
  assign bus.light_b = r_light_b;
  assign bus.phase   = r_state;
`ifdef CYCLIC_LAMP_PED_EN
  logic r_ped_pend, r_walk_b, r_walk, r_ack;
  // pending request, walk return target and walk outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ped_pend <= 1'b0;
      r_walk_b   <= 1'b0;
      r_walk     <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      r_ped_pend <= bus.flash_req ? 1'b0 :
                    w_walk_entry  ? 1'b0 :
                    (bus.ped_req && r_state != WALK) ? 1'b1 : r_ped_pend;
      if (w_walk_entry) r_walk_b <= r_state == CLR_1;
      r_walk     <= w_nxt == WALK;
      r_ack      <= w_walk_entry;
    end
  end
  assign w_pend      = r_ped_pend;
  assign w_walk_b    = r_walk_b;
  assign bus.walk    = r_walk;
  assign bus.ped_ack = r_ack;
`else
  assign w_pend      = 1'b0;
  assign w_walk_b    = w_walk_entry & 1'b0;
  assign bus.walk    = 1'b0;
  assign bus.ped_ack = 1'b0;
`endif
endmodule
